// File: rtl/mfp_ahb_io_master_pkg.sv
// Shared AHB-Lite encodings, FSM state codes and the latched command record
// used by the single-outstanding AHB-Lite I/O master.
package mfp_ahb_io_master_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    typedef struct packed {
        logic        write;
        logic [31:0] wdata;
    } cmd_t;

    function automatic logic is_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/mfp_ahb_io_master_if.sv
// Command, response and AHB-Lite manager signals of the I/O master, with the
// master (block) and slave (environment) views.
interface mfp_ahb_io_master_if;

    // cmd and rsp are valid/ready: a beat transfers on a rising edge where both
    // are 1; the sender holds valid and its payload stable until that edge.
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;

    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  HRDATA, HREADY, HRESP,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output HRDATA, HREADY, HRESP,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA
    );

endinterface

// File: rtl/mfp_ahb_master_timeout.sv
// Consecutive wait-state counter; expired fires on the wait cycle that
// brings the run of HREADY=0 cycles up to TIMEOUT_CYCLES.
module mfp_ahb_master_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic HCLK,
    input  logic HRESET,
    input  logic wait_cycle,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    assign expired = wait_cycle && (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge HCLK) begin
        if (HRESET || clear || expired) begin
            count <= '0;
        end else if (wait_cycle) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/mfp_ahb_io_master.sv
// Single-outstanding AHB-Lite I/O master: one word transfer per command.
// Define MFP_AHB_MASTER_TIMEOUT_EN to bound wait states at TIMEOUT_CYCLES.
module mfp_ahb_io_master
    import mfp_ahb_io_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                       HCLK,
    input  logic                       HRESET,
    mfp_ahb_io_master_if.master        bus,
    output logic [1:0]                 state_dbg
);

    logic [1:0] state;
    cmd_t       cmd_q;
    logic       timed_out;

    assign bus.cmd_ready = (state == ST_IDLE);
    assign state_dbg     = state;

`ifdef MFP_AHB_MASTER_TIMEOUT_EN
    logic wait_cycle;
    logic phase_done;
    logic rsp_timeout_q;

    assign wait_cycle = ((state == ST_ADDR) || (state == ST_DATA)) && !bus.HREADY;
    assign phase_done = ((state == ST_ADDR) || (state == ST_DATA)) && bus.HREADY;

    mfp_ahb_master_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .wait_cycle (wait_cycle),
        .clear      (phase_done),
        .expired    (timed_out)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rsp_timeout_q <= 1'b0;
        end else if ((state == ST_IDLE) && bus.cmd_valid) begin
            rsp_timeout_q <= 1'b0;
        end else if (timed_out) begin
            rsp_timeout_q <= 1'b1;
        end
    end

    assign bus.rsp_timeout = rsp_timeout_q;
`else
    assign timed_out       = 1'b0;
    assign bus.rsp_timeout = 1'b0;
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state         <= ST_IDLE;
            cmd_q         <= '0;
            bus.HADDR     <= '0;
            bus.HTRANS    <= HTRANS_IDLE;
            bus.HWRITE    <= 1'b0;
            bus.HWDATA    <= '0;
            bus.HSIZE     <= HSIZE_WORD;
            bus.HBURST    <= HBURST_SINGLE;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        cmd_q <= '{write: bus.cmd_write, wdata: bus.cmd_wdata};
                        if (is_aligned(bus.cmd_addr[1:0])) begin
                            state      <= ST_ADDR;
                            bus.HTRANS <= HTRANS_NONSEQ;
                            bus.HADDR  <= bus.cmd_addr;
                            bus.HWRITE <= bus.cmd_write;
                        end else begin
                            // Misaligned: answer with an error, the bus never sees it.
                            state         <= ST_RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= '0;
                        end
                    end
                end
                ST_ADDR: begin
                    if (timed_out) begin
                        state         <= ST_RESP;
                        bus.HTRANS    <= HTRANS_IDLE;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= '0;
                    end else if (bus.HREADY) begin
                        state      <= ST_DATA;
                        bus.HTRANS <= HTRANS_IDLE;
                        bus.HWDATA <= cmd_q.write ? cmd_q.wdata : 32'h0;
                    end
                end
                ST_DATA: begin
                    if (timed_out) begin
                        state         <= ST_RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= '0;
                    end else if (bus.HREADY) begin
                        state         <= ST_RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= bus.HRESP;
                        bus.rsp_rdata <= (!cmd_q.write && !bus.HRESP) ? bus.HRDATA : 32'h0;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= ST_IDLE;
                        bus.rsp_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mfp_ahb_io_master.sv
// Directed and randomized bench for mfp_ahb_io_master; responses are checked
// against an expected queue filled when each command is issued.
module tb_mfp_ahb_io_master;

`ifdef MFP_AHB_MASTER_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif
    localparam int W = 34;  // {err, timeout, rdata}

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic [1:0] state_dbg;

    mfp_ahb_io_master_if bus();

    mfp_ahb_io_master #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .bus       (bus.master),
        .state_dbg (state_dbg)
    );

    logic [W-1:0] exp_q[$];
    int vectors = 0;
    int fails   = 0;

    // ---------------- clock / reset ----------------
    always #5 HCLK = ~HCLK;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge HCLK);
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_wdata = 32'h0;
    endtask

    task automatic finish_rsp();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        HRESET = 1'b1;
        tick();
        tick();
        vectors++;
        if ({bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HWDATA, bus.HSIZE, bus.HBURST} !==
            {2'b00, 32'h0, 1'b0, 32'h0, 3'b010, 3'b000}) begin
            fails++;
            $display("FAIL reset_ahb: got %h want %h",
                     {bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HWDATA, bus.HSIZE, bus.HBURST},
                     {2'b00, 32'h0, 1'b0, 32'h0, 3'b010, 3'b000});
        end
        vectors++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata, state_dbg} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0}) begin
            fails++;
            $display("FAIL reset_rsp: got %h want %h",
                     {bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata, state_dbg},
                     {1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0});
        end
        HRESET = 1'b0;
        tick();
        vectors++;
        if (bus.cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b want 1", bus.cmd_ready);
        end
    endtask

    task automatic test_write_zero_wait();
        logic [W-1:0] got, exp_v;
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 32'h0});
        issue(1'b1, 32'h1F800010, 32'h000000A5);
        vectors++;
        if ({bus.HTRANS, bus.HWRITE, bus.HADDR} !== {2'b10, 1'b1, 32'h1F800010}) begin
            fails++;
            $display("FAIL wr_addr_phase: got %h want %h", {bus.HTRANS, bus.HWRITE, bus.HADDR},
                     {2'b10, 1'b1, 32'h1F800010});
        end
        tick();
        vectors++;
        if ({bus.HTRANS, bus.HWDATA, bus.rsp_valid} !== {2'b00, 32'hA5, 1'b0}) begin
            fails++;
            $display("FAIL wr_data_phase: got %h want %h", {bus.HTRANS, bus.HWDATA, bus.rsp_valid},
                     {2'b00, 32'hA5, 1'b0});
        end
        tick();
        vectors++;
        if (bus.rsp_valid !== 1'b1) begin
            fails++;
            $display("FAIL wr_rsp_valid: got %b want 1", bus.rsp_valid);
        end
        got   = {bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata};
        exp_v = exp_q.pop_front();
        vectors++;
        if (got !== exp_v) begin
            fails++;
            $display("FAIL wr_rsp: got %h want %h", got, exp_v);
        end
        finish_rsp();
        vectors++;
        if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
            fails++;
            $display("FAIL wr_return_idle: got %b want 01", {bus.rsp_valid, bus.cmd_ready});
        end
    endtask

    task automatic test_read_data_waits();
        logic [W-1:0] got, exp_v;
        bus.HREADY = 1'b1;
        bus.HRDATA = 32'hFFFF0000;
        exp_q.push_back({1'b0, 1'b0, 32'h12345678});
        issue(1'b0, 32'h1F80000C, 32'h5555AAAA);
        vectors++;
        if ({bus.HTRANS, bus.HWRITE, bus.HADDR} !== {2'b10, 1'b0, 32'h1F80000C}) begin
            fails++;
            $display("FAIL rd_addr_phase: got %h want %h", {bus.HTRANS, bus.HWRITE, bus.HADDR},
                     {2'b10, 1'b0, 32'h1F80000C});
        end
        tick();
        bus.HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({bus.HWDATA, bus.HTRANS, bus.rsp_valid} !== {32'h0, 2'b00, 1'b0}) begin
                fails++;
                $display("FAIL rd_wait%0d: got %h want %h", i, {bus.HWDATA, bus.HTRANS, bus.rsp_valid},
                         {32'h0, 2'b00, 1'b0});
            end
            tick();
        end
        bus.HREADY = 1'b1;
        bus.HRDATA = 32'h12345678;
        tick();
        vectors++;
        if (bus.rsp_valid !== 1'b1) begin
            fails++;
            $display("FAIL rd_rsp_valid_n6: got %b want 1", bus.rsp_valid);
        end
        got   = {bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata};
        exp_v = exp_q.pop_front();
        vectors++;
        if (got !== exp_v) begin
            fails++;
            $display("FAIL rd_rsp: got %h want %h", got, exp_v);
        end
        // Backpressure: response must hold while the bus keeps changing.
        bus.HRDATA = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata} !==
                {1'b1, 1'b0, 1'b0, 32'h12345678}) begin
                fails++;
                $display("FAIL rsp_hold%0d: got %h want %h", i,
                         {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata},
                         {1'b1, 1'b0, 1'b0, 32'h12345678});
            end
        end
        finish_rsp();
        vectors++;
        if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01) begin
            fails++;
            $display("FAIL rd_return_idle: got %b want 01", {bus.rsp_valid, bus.cmd_ready});
        end
    endtask

    task automatic test_error();
        logic [W-1:0] got, exp_v;
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        exp_q.push_back({1'b1, 1'b0, 32'h0});
        issue(1'b0, 32'h1F800020, 32'h0);
        tick();
        bus.HREADY = 1'b0;
        bus.HRESP  = 1'b1;
        bus.HRDATA = 32'hDEADBEEF;
        vectors++;
        if ({bus.HTRANS, bus.rsp_valid} !== 3'b000) begin
            fails++;
            $display("FAIL err_cycle1: got %b want 000", {bus.HTRANS, bus.rsp_valid});
        end
        tick();
        bus.HREADY = 1'b1;
        vectors++;
        if ({bus.HTRANS, bus.rsp_valid} !== 3'b000) begin
            fails++;
            $display("FAIL err_cycle2: got %b want 000", {bus.HTRANS, bus.rsp_valid});
        end
        tick();
        bus.HRESP = 1'b0;
        vectors++;
        if ({bus.rsp_valid, bus.HTRANS} !== 3'b100) begin
            fails++;
            $display("FAIL err_rsp_valid: got %b want 100", {bus.rsp_valid, bus.HTRANS});
        end
        got   = {bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata};
        exp_v = exp_q.pop_front();
        vectors++;
        if (got !== exp_v) begin
            fails++;
            $display("FAIL err_rsp: got %h want %h", got, exp_v);
        end
        finish_rsp();
    endtask

    task automatic test_misaligned();
        logic [W-1:0] got, exp_v;
        bus.HREADY = 1'b1;
        exp_q.push_back({1'b1, 1'b0, 32'h0});
        issue(1'b1, 32'h1F800012, 32'h11);
        vectors++;
        if ({bus.HTRANS, bus.rsp_valid, state_dbg} !== {2'b00, 1'b1, 2'd3}) begin
            fails++;
            $display("FAIL mis_one_cycle: got %b want %b", {bus.HTRANS, bus.rsp_valid, state_dbg},
                     {2'b00, 1'b1, 2'd3});
        end
        got   = {bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata};
        exp_v = exp_q.pop_front();
        vectors++;
        if (got !== exp_v) begin
            fails++;
            $display("FAIL mis_rsp: got %h want %h", got, exp_v);
        end
        tick();
        vectors++;
        if ({bus.HTRANS, bus.rsp_valid} !== 3'b001) begin
            fails++;
            $display("FAIL mis_hold: got %b want 001", {bus.HTRANS, bus.rsp_valid});
        end
        finish_rsp();
        vectors++;
        if ({bus.HTRANS, state_dbg} !== 4'b0000) begin
            fails++;
            $display("FAIL mis_idle: got %b want 0000", {bus.HTRANS, state_dbg});
        end
    endtask

    task automatic test_timeout();
        logic [W-1:0] got, exp_v;
        int n_wait;
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        issue(1'b0, 32'h1F800030, 32'h0);
        bus.HREADY = 1'b0;
        bus.HRDATA = 32'h00000077;
`ifdef MFP_AHB_MASTER_TIMEOUT_EN
        exp_q.push_back({1'b1, 1'b1, 32'h0});
        n_wait = 3;
`else
        exp_q.push_back({1'b0, 1'b0, 32'h00000077});
        n_wait = 8;
`endif
        for (int i = 0; i < n_wait; i++) begin
            tick();
            vectors++;
            if ({bus.rsp_valid, bus.HTRANS, bus.HADDR} !== {1'b0, 2'b10, 32'h1F800030}) begin
                fails++;
                $display("FAIL to_addr_hold%0d: got %h want %h", i, {bus.rsp_valid, bus.HTRANS, bus.HADDR},
                         {1'b0, 2'b10, 32'h1F800030});
            end
        end
`ifndef MFP_AHB_MASTER_TIMEOUT_EN
        bus.HREADY = 1'b1;
        tick();
        vectors++;
        if ({bus.rsp_valid, bus.HTRANS} !== 3'b000) begin
            fails++;
            $display("FAIL nto_data_phase: got %b want 000", {bus.rsp_valid, bus.HTRANS});
        end
`endif
        tick();
        vectors++;
        if ({bus.rsp_valid, bus.HTRANS} !== 3'b100) begin
            fails++;
            $display("FAIL to_rsp_valid: got %b want 100", {bus.rsp_valid, bus.HTRANS});
        end
        got   = {bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata};
        exp_v = exp_q.pop_front();
        vectors++;
        if (got !== exp_v) begin
            fails++;
            $display("FAIL to_rsp: got %h want %h", got, exp_v);
        end
        finish_rsp();
        bus.HREADY = 1'b1;
        vectors++;
        if ({state_dbg, bus.cmd_ready, bus.rsp_valid} !== 4'b0010) begin
            fails++;
            $display("FAIL to_idle: got %b want 0010", {state_dbg, bus.cmd_ready, bus.rsp_valid});
        end
    endtask

    task automatic test_reset_in_data();
        bus.HREADY = 1'b1;
        issue(1'b1, 32'h1F800040, 32'h0000BEEF);
        tick();
        bus.HREADY = 1'b0;
        vectors++;
        if ({bus.HWDATA, state_dbg} !== {32'h0000BEEF, 2'd2}) begin
            fails++;
            $display("FAIL rst_pre_data: got %h want %h", {bus.HWDATA, state_dbg}, {32'h0000BEEF, 2'd2});
        end
        tick();
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        vectors++;
        if ({bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HWDATA, bus.cmd_ready, bus.rsp_valid, state_dbg} !==
            {2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 2'd0}) begin
            fails++;
            $display("FAIL rst_mid_xfer: got %h want %h",
                     {bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HWDATA, bus.cmd_ready, bus.rsp_valid, state_dbg},
                     {2'b00, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 2'd0});
        end
        bus.HREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({bus.rsp_valid, bus.HTRANS} !== 3'b000) begin
                fails++;
                $display("FAIL rst_no_rsp%0d: got %b want 000", i, {bus.rsp_valid, bus.HTRANS});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] got, exp_v;
        logic         w;
        logic [31:0]  addr, wd, rdat, exp_hwdata;
        int           a_w, d_w, r_d;
        for (int n = 0; n < 8; n++) begin
            w          = 1'($urandom_range(0, 1));
            addr       = $urandom() & 32'hFFFFFFFC;
            wd         = $urandom();
            rdat       = $urandom();
            a_w        = $urandom_range(0, 3);
            d_w        = $urandom_range(0, 3);
            r_d        = $urandom_range(0, 2);
            exp_hwdata = w ? wd : 32'h0;
            exp_q.push_back({2'b00, (w ? 32'h0 : rdat)});
            bus.HREADY = 1'b1;
            bus.HRESP  = 1'b0;
            bus.HRDATA = ~rdat;
            vectors++;
            if (bus.cmd_ready !== 1'b1) begin
                fails++;
                $display("FAIL b2b%0d_ready: got %b want 1", n, bus.cmd_ready);
            end
            issue(w, addr, wd);
            if (a_w != 0) begin
                bus.HREADY = 1'b0;
                for (int i = 0; i < a_w; i++) tick();
                bus.HREADY = 1'b1;
            end
            vectors++;
            if ({bus.HTRANS, bus.HWRITE, bus.HADDR} !== {2'b10, w, addr}) begin
                fails++;
                $display("FAIL b2b%0d_addr: got %h want %h", n, {bus.HTRANS, bus.HWRITE, bus.HADDR},
                         {2'b10, w, addr});
            end
            tick();
            if (d_w != 0) begin
                bus.HREADY = 1'b0;
                for (int i = 0; i < d_w; i++) tick();
                bus.HREADY = 1'b1;
            end
            vectors++;
            if ({bus.HTRANS, bus.HWDATA, bus.rsp_valid} !== {2'b00, exp_hwdata, 1'b0}) begin
                fails++;
                $display("FAIL b2b%0d_data: got %h want %h", n, {bus.HTRANS, bus.HWDATA, bus.rsp_valid},
                         {2'b00, exp_hwdata, 1'b0});
            end
            bus.HRDATA = rdat;
            tick();
            vectors++;
            if (bus.rsp_valid !== 1'b1) begin
                fails++;
                $display("FAIL b2b%0d_latency: got %b want 1 (waits %0d/%0d)", n, bus.rsp_valid, a_w, d_w);
            end
            got   = {bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata};
            exp_v = exp_q.pop_front();
            vectors++;
            if (got !== exp_v) begin
                fails++;
                $display("FAIL b2b%0d_rsp: got %h want %h", n, got, exp_v);
            end
            for (int i = 0; i < r_d; i++) tick();
            finish_rsp();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        HRESET        = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_wdata = 32'h0;
        bus.rsp_ready = 1'b0;
        bus.HRDATA    = 32'h0;
        bus.HREADY    = 1'b1;
        bus.HRESP     = 1'b0;

        test_reset();
        test_write_zero_wait();
        test_read_data_waits();
        test_error();
        test_misaligned();
        test_timeout();
        test_reset_in_data();
        test_back_to_back();

        vectors++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
